// File: rtl/snake_dir_ctrl_pkg.sv
// Shared definitions for the snake direction controller: direction codes,
// button slice indices and the reversal test.
package snake_dir_ctrl_pkg;

    localparam int DIR_W = 3;

    localparam logic [DIR_W-1:0] DIR_UP    = 3'd1;
    localparam logic [DIR_W-1:0] DIR_RIGHT = 3'd2;
    localparam logic [DIR_W-1:0] DIR_DOWN  = 3'd3;
    localparam logic [DIR_W-1:0] DIR_LEFT  = 3'd4;

    localparam int BTN_UP    = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_LEFT  = 3;

    // Opposite directions are exactly two codes apart (up/down, right/left).
    function automatic logic is_opposite(input logic [DIR_W-1:0] a,
                                         input logic [DIR_W-1:0] b);
        logic [DIR_W-1:0] diff;
        diff = (a > b) ? (a - b) : (b - a);
        return diff == DIR_W'(2);
    endfunction

endpackage

// File: rtl/snake_dir_ctrl_debounce.sv
// One active-low button: 2-flop synchroniser, stability counter and a
// one-cycle pulse on each debounced press (1->0).
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw_n,
    output logic press
);

    localparam logic [DB_CNT_W-1:0] LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic                sync_p0;
    logic                sync_p1;
    logic                level;
    logic [DB_CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            level   <= 1'b1;
            cnt     <= '0;
            press   <= 1'b0;
        end else begin
            sync_p0 <= raw_n;
            sync_p1 <= sync_p0;
            press   <= 1'b0;
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                // Level flips here; a flip away from 1 is a press.
                level <= sync_p1;
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// Per-player direction controller: debounced presses are filtered against
// reversal/duplicate, queued, and committed to dir one per game tick.
module snake_dir_ctrl
    import snake_dir_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int DB_CNT_W        = 20,
    parameter int QUEUE_DEPTH     = 2,
    parameter int INIT_DIR        = 2
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [4*NUM_PLAYERS-1:0]     btn_n,
    input  logic                         tick,
    input  logic                         clear,
    output logic [DIR_W*NUM_PLAYERS-1:0] dir,
    output logic [NUM_PLAYERS-1:0]       pending,
    output logic [NUM_PLAYERS-1:0]       turn_drop
);

    localparam int               CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [DIR_W-1:0] INIT  = DIR_W'(INIT_DIR);

    logic [4*NUM_PLAYERS-1:0] press;

    for (genvar b = 0; b < 4*NUM_PLAYERS; b++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .DB_CNT_W       (DB_CNT_W)
        ) u_db (
            .clock (clock),
            .resetn(resetn),
            .raw_n (btn_n[b]),
            .press (press[b])
        );
    end

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0]       ev;
        logic [DIR_W-1:0] mem   [QUEUE_DEPTH];
        logic [DIR_W-1:0] mem_n [QUEUE_DEPTH];
        logic [DIR_W-1:0] dir_q;
        logic [DIR_W-1:0] dir_n;
        logic [DIR_W-1:0] cand;
        logic [DIR_W-1:0] ref_dir;
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] count_n;
        logic [CNT_W-1:0] wr_pos;
        logic             drop_q;
        logic             drop_n;
        logic             accept;
        logic             do_pop;
        logic             do_push;

        assign ev = press[4*p +: 4];

        always_comb begin
            cand = '0;
            if (ev[BTN_UP])         cand = DIR_UP;
            else if (ev[BTN_RIGHT]) cand = DIR_RIGHT;
            else if (ev[BTN_DOWN])  cand = DIR_DOWN;
            else if (ev[BTN_LEFT])  cand = DIR_LEFT;

            // Compare against the last queued turn, not the one on screen.
            ref_dir = dir_q;
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (count == CNT_W'(i + 1)) ref_dir = mem[i];
            end

            accept  = (cand != '0) && (cand != ref_dir) && !is_opposite(cand, ref_dir);
            do_pop  = tick && (count != '0);
            drop_n  = accept && (count == CNT_W'(QUEUE_DEPTH)) && !tick;
            do_push = accept && !drop_n;
            wr_pos  = count - CNT_W'(do_pop);

            mem_n = mem;
            if (do_pop) begin
                for (int i = 0; i < QUEUE_DEPTH - 1; i++) mem_n[i] = mem[i+1];
            end
            if (do_push) begin
                for (int i = 0; i < QUEUE_DEPTH; i++) begin
                    if (wr_pos == CNT_W'(i)) mem_n[i] = cand;
                end
            end

            count_n = count + CNT_W'(do_push) - CNT_W'(do_pop);
            dir_n   = do_pop ? mem[0] : dir_q;

            if (clear) begin
                dir_n   = INIT;
                count_n = '0;
                drop_n  = 1'b0;
            end
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                dir_q  <= INIT;
                count  <= '0;
                drop_q <= 1'b0;
            end else begin
                dir_q  <= dir_n;
                count  <= count_n;
                drop_q <= drop_n;
            end
        end

        // Slot contents are only meaningful below count, so they need no reset.
        always_ff @(posedge clock) begin
            mem <= mem_n;
        end

        assign dir[DIR_W*p +: DIR_W] = dir_q;
        assign pending[p]            = (count != '0);
        assign turn_drop[p]          = drop_q;
    end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Randomised and directed bench for snake_dir_ctrl against a behavioural
// model of button stability, turn filtering and per-player turn queues.
module tb_snake_dir_ctrl;

    localparam int NP = 2;
    localparam int DB = 4;
    localparam int QD = 2;

    logic       clock = 1'b0;
    logic       resetn;
    logic [7:0] btn_n;
    logic       tick;
    logic       clear;
    logic [5:0] dir;
    logic [1:0] pending;
    logic [1:0] turn_drop;

    always #5 clock = ~clock;

    snake_dir_ctrl #(
        .NUM_PLAYERS    (NP),
        .DEBOUNCE_CYCLES(DB),
        .DB_CNT_W       (3),
        .QUEUE_DEPTH    (QD),
        .INIT_DIR       (2)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .btn_n    (btn_n),
        .tick     (tick),
        .clear    (clear),
        .dir      (dir),
        .pending  (pending),
        .turn_drop(turn_drop)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: pin samples delayed two clocks, a run of DB
    // differing samples flips the stable level, a stable 1->0 is a press
    // seen by the turn logic on the following clock.
    int d0 [8];
    int d1 [8];
    int stable [8];
    int run [8];
    bit ev [8];
    int mdir [2];
    int qb [2][4];
    int qn [2];
    bit mdrop [2];

    task automatic model_reset();
        for (int b = 0; b < 8; b++) begin
            d0[b] = 1; d1[b] = 1; stable[b] = 1; run[b] = 0; ev[b] = 0;
        end
        for (int p = 0; p < 2; p++) begin
            mdir[p] = 2; qn[p] = 0; mdrop[p] = 0;
        end
    endtask

    task automatic model_step();
        int  cand;
        int  refd;
        int  smp;
        bit  full;
        bit  acc;
        bit  nev;
        for (int p = 0; p < 2; p++) begin
            cand = 0;
            if (ev[4*p])        cand = 1;
            else if (ev[4*p+1]) cand = 2;
            else if (ev[4*p+2]) cand = 3;
            else if (ev[4*p+3]) cand = 4;
            mdrop[p] = 0;
            if (clear) begin
                mdir[p] = 2;
                qn[p]   = 0;
            end else begin
                refd = (qn[p] > 0) ? qb[p][qn[p]-1] : mdir[p];
                full = (qn[p] == QD);
                acc  = (cand != 0) && (cand != refd) && (cand - refd != 2) && (refd - cand != 2);
                if (tick && qn[p] > 0) begin
                    mdir[p] = qb[p][0];
                    for (int k = 0; k < 3; k++) qb[p][k] = qb[p][k+1];
                    qn[p]--;
                end
                if (acc) begin
                    if (full && !tick) mdrop[p] = 1;
                    else begin
                        qb[p][qn[p]] = cand;
                        qn[p]++;
                    end
                end
            end
        end
        for (int b = 0; b < 8; b++) begin
            smp = d1[b];
            nev = 0;
            if (smp == stable[b]) run[b] = 0;
            else begin
                run[b]++;
                if (run[b] == DB) begin
                    nev       = (stable[b] == 1);
                    stable[b] = smp;
                    run[b]    = 0;
                end
            end
            d1[b] = d0[b];
            d0[b] = int'(btn_n[b]);
            ev[b] = nev;
        end
    endtask

    always @(posedge clock) begin
        if (!resetn) model_reset();
        else         model_step();
    end

    always @(negedge clock) begin
        if (resetn) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("dir%0d", p), int'(dir[3*p +: 3]), mdir[p]);
                chk($sformatf("pending%0d", p), int'(pending[p]), (qn[p] > 0) ? 1 : 0);
                chk($sformatf("turn_drop%0d", p), int'(turn_drop[p]), int'(mdrop[p]));
            end
        end
    end

    int drops0 = 0;
    always @(negedge clock) begin
        if (resetn && turn_drop[0]) drops0++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    task automatic press(input int b);
        btn_n[b] = 1'b0;
        repeat (8) @(negedge clock);
        btn_n[b] = 1'b1;
        repeat (8) @(negedge clock);
    endtask

    task automatic tick_pulse();
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        @(negedge clock);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        @(negedge clock);
    endtask

    int hold [8];
    int base;

    initial begin
        resetn = 1'b0;
        btn_n  = 8'hFE;
        tick   = 1'b0;
        clear  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_dir", int'(dir), 18);
        chk("rst_pending", int'(pending), 0);
        chk("rst_drop", int'(turn_drop), 0);
        #2 resetn = 1'b1;
        repeat (10) @(negedge clock);
        chk("held_pending0", int'(pending[0]), 1);
        tick_pulse();
        chk("held_dir0", int'(dir[2:0]), 1);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clock);

        btn_n[4] = 1'b0;
        repeat (3) @(negedge clock);
        btn_n[4] = 1'b1;
        repeat (12) @(negedge clock);
        chk("glitch_pending1", int'(pending[1]), 0);
        btn_n[4] = 1'b0;
        repeat (10) @(negedge clock);
        btn_n[4] = 1'b1;
        repeat (12) @(negedge clock);
        chk("long_pending1", int'(pending[1]), 1);
        tick_pulse();
        chk("long_dir1", int'(dir[5:3]), 1);
        clear_pulse();
        chk("clear_dir", int'(dir), 18);

        press(3);
        chk("reverse_pending0", int'(pending[0]), 0);
        press(1);
        chk("dup_pending0", int'(pending[0]), 0);
        press(2);
        chk("turn_pending0", int'(pending[0]), 1);
        tick_pulse();
        chk("turn_dir0", int'(dir[2:0]), 3);

        clear_pulse();
        base = drops0;
        press(0);
        press(3);
        press(2);
        chk("fill_drops", drops0 - base, 1);
        chk("fill_pending0", int'(pending[0]), 1);

        base = drops0;
        btn_n[2] = 1'b0;
        repeat (6) @(negedge clock);
        tick = 1'b1;
        @(negedge clock);
        tick = 1'b0;
        chk("simul_dir0", int'(dir[2:0]), 1);
        chk("simul_pending0", int'(pending[0]), 1);
        btn_n[2] = 1'b1;
        repeat (10) @(negedge clock);
        chk("simul_drops", drops0 - base, 0);
        tick_pulse();
        chk("pop_dir0_a", int'(dir[2:0]), 4);
        tick_pulse();
        chk("pop_dir0_b", int'(dir[2:0]), 3);
        chk("pop_pending0", int'(pending[0]), 0);

        press(1);
        chk("preclr_pending0", int'(pending[0]), 1);
        btn_n[0] = 1'b0;
        repeat (6) @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        chk("clr_dir0", int'(dir[2:0]), 2);
        chk("clr_pending0", int'(pending[0]), 0);
        chk("clr_drop0", int'(turn_drop[0]), 0);
        chk("clr_dir1", int'(dir[5:3]), 2);
        repeat (10) @(negedge clock);
        chk("clr_held_pending0", int'(pending[0]), 0);
        btn_n[0] = 1'b1;
        repeat (10) @(negedge clock);

        btn_n[6] = 1'b0;
        repeat (10) @(negedge clock);
        #2 resetn = 1'b0;
        repeat (3) @(negedge clock);
        chk("midrst_dir", int'(dir), 18);
        chk("midrst_pending", int'(pending), 0);
        #2 resetn = 1'b1;
        repeat (12) @(negedge clock);
        chk("midrst_held_pending1", int'(pending[1]), 1);
        btn_n[6] = 1'b1;
        repeat (10) @(negedge clock);

        for (int b = 0; b < 8; b++) hold[b] = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            for (int b = 0; b < 8; b++) begin
                if (hold[b] == 0) begin
                    btn_n[b] = ($urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
                    hold[b]  = int'($urandom_range(1, 12));
                end else begin
                    hold[b]--;
                end
            end
            tick  = ($urandom_range(0, 4) == 0);
            clear = ($urandom_range(0, 80) == 0);
        end
        tick  = 1'b0;
        clear = 1'b0;
        btn_n = 8'hFF;
        repeat (20) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
